// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS pipeline blocks.
//   - MDU operation codes carried on the op input of mdu_iterative.
//   - MDU sequencer state encoding (IDLE -> PREP -> ITER -> FIX).
//   - Small helpers that decode an MDU op code.
// -----------------------------------------------------------------------------
package mips_pkg;

    // MDU operation codes: bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    // MDU sequencer states.
    localparam logic [1:0] MDU_IDLE = 2'b00;
    localparam logic [1:0] MDU_PREP = 2'b01;
    localparam logic [1:0] MDU_ITER = 2'b10;
    localparam logic [1:0] MDU_FIX  = 2'b11;

    // True for DIV/DIVU.
    function automatic logic mduIsDiv(input logic [1:0] opCode);
        return opCode[1];
    endfunction

    // True for the two's-complement ops MULT/DIV.
    function automatic logic mduIsSigned(input logic [1:0] opCode);
        return ~opCode[0];
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// -----------------------------------------------------------------------------
// mdu_iter_core
// One combinational step of the iterative multiply/divide datapath.
//   acc       in   2*WIDTH  working register
//                           multiply: {partial product high, remaining multiplier}
//                           divide:   {partial remainder, remaining dividend/quotient}
//   operand   in   WIDTH    multiplicand magnitude (multiply) or divisor magnitude (divide)
//   op_is_div in   1        1 = restoring-divide step, 0 = shift-add multiply step
//   acc_next  out  2*WIDTH  working register after this step
//   q_bit     out  1        quotient bit produced by a divide step (0 for multiply)
// -----------------------------------------------------------------------------
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               op_is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   window;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole register right,
    // carrying the adder carry into the top bit.
    // Divide: shift the next dividend bit into the partial remainder (window)
    // and subtract the divisor when it fits. The remainder is always below the
    // divisor, so a successful difference fits in WIDTH bits. Bit 0 of the
    // divide result is left clear; the caller merges q_bit there.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        window   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        fits     = (window >= {1'b0, operand});
        diff     = window[WIDTH-1:0] - operand;
        acc_next = '0;
        q_bit    = 1'b0;
        if (op_is_div) begin
            q_bit = fits;
            if (fits) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// -----------------------------------------------------------------------------
// mdu_iterative
// Iterative multiply/divide unit with architectural HI/LO registers. Sits in EX
// beside the ALU; MULT/MULTU/DIV/DIVU take WIDTH+2 cycles and raise busy so the
// hazard logic stalls MFHI/MFLO and further MDU ops.
//   clk     in   1      clock
//   rst     in   1      asynchronous active-high reset
//   start   in   1      launch op with a/b (taken only when idle)
//   op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a       in   WIDTH  multiplicand / dividend
//   b       in   WIDTH  multiplier / divisor
//   cancel  in   1      abort the op in flight, HI/LO untouched
//   hi_we   in   1      MTHI write (idle only)
//   lo_we   in   1      MTLO write (idle only)
//   wdata   in   WIDTH  MTHI/MTLO data
//   busy    out  1      op in flight
//   done    out  1      one-cycle pulse, HI/LO already hold the result
//   hi      out  WIDTH  HI register (product high / remainder)
//   lo      out  WIDTH  LO register (product low / quotient)
// -----------------------------------------------------------------------------
module mdu_iterative
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITR = CW'(WIDTH - 1);

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [1:0]         op_q,      op_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic [WIDTH-1:0]   b_q,       b_d;
    logic [WIDTH-1:0]   opnd_q,    opnd_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic               negRes_q,  negRes_d;
    logic               negRem_q,  negRem_d;
    logic               divZero_q, divZero_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               done_q,    done_d;

    logic [2*WIDTH-1:0] coreNext;
    logic               coreQBit;
    logic               aNeg, bNeg;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix, remFix;

    mdu_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .acc      (acc_q),
        .operand  (opnd_q),
        .op_is_div(mduIsDiv(op_q)),
        .acc_next (coreNext),
        .q_bit    (coreQBit)
    );

    // Magnitudes of the latched operands and the sign-corrected results.
    // The core always works on unsigned magnitudes; the sign flags recorded
    // in PREP are applied once in FIX. MIN_INT keeps its bit pattern as a
    // magnitude, which is exactly 2^(WIDTH-1) when read as unsigned.
    always_comb begin
        aNeg    = mduIsSigned(op_q) & a_q[WIDTH-1];
        bNeg    = mduIsSigned(op_q) & b_q[WIDTH-1];
        aMag    = aNeg ? -a_q : a_q;
        bMag    = bNeg ? -b_q : b_q;
        prodFix = negRes_q ? -acc_q : acc_q;
        quoFix  = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        remFix  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Sequencer. IDLE takes MTHI/MTLO writes and new ops; PREP loads the
    // working register with magnitudes; ITER runs exactly WIDTH core steps
    // regardless of operand values; FIX commits HI/LO and raises done for the
    // following cycle, when the unit is already back in IDLE. Cancel in any
    // busy state drops the op without touching HI/LO, and a start that
    // coincides with cancel is ignored.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (hi_we) begin
                    hi_d = wdata;
                end
                if (lo_we) begin
                    lo_d = wdata;
                end
                if (start && !cancel) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = MDU_PREP;
                end
            end

            MDU_PREP: begin
                if (cancel) begin
                    state_d = MDU_IDLE;
                end else begin
                    negRes_d = aNeg ^ bNeg;
                    if (mduIsDiv(op_q)) begin
                        acc_d     = {{WIDTH{1'b0}}, aMag};
                        opnd_d    = bMag;
                        negRem_d  = aNeg;
                        divZero_d = (b_q == '0);
                    end else begin
                        acc_d     = {{WIDTH{1'b0}}, bMag};
                        opnd_d    = aMag;
                        negRem_d  = 1'b0;
                        divZero_d = 1'b0;
                    end
                    cnt_d   = '0;
                    state_d = MDU_ITER;
                end
            end

            MDU_ITER: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = MDU_IDLE;
                end else begin
                    acc_d = {coreNext[2*WIDTH-1:1],
                             mduIsDiv(op_q) ? coreQBit : coreNext[0]};
                    if (cnt_q == LAST_ITR) begin
                        cnt_d   = '0;
                        state_d = MDU_FIX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            MDU_FIX: begin
                if (!cancel) begin
                    if (!mduIsDiv(op_q)) begin
                        {hi_d, lo_d} = prodFix;
                    end else if (divZero_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = quoFix;
                        hi_d = remFix;
                    end
                    done_d = 1'b1;
                end
                state_d = MDU_IDLE;
            end

            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything including HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            op_q      <= MDU_MULT;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        busy = (state_q != MDU_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// -----------------------------------------------------------------------------
// tb_mdu_iterative
// Scoreboard bench for mdu_iterative: each launched op pushes its expected
// {HI,LO} from a reference model; each done pulse pops and compares.
// -----------------------------------------------------------------------------
module tb_mdu_iterative;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    exp_t         sbQ[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [W-1:0] lastHi   = '0;
    logic [W-1:0] lastLo   = '0;

    mdu_iterative #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cancel(cancel),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock and edge counter used for latency measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Reference model written directly from the arithmetic definitions.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t        e;
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        e = '0;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                up = 64'(sp);
                e  = up;
            end
            2'b01: begin
                up = {32'b0, x} * {32'b0, y};
                e  = up;
            end
            2'b10: begin
                if (y == 0) begin
                    e.lo = '1;
                    e.hi = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = '0;
                end else begin
                    sa   = x;
                    sb   = y;
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end
            end
            default: begin
                if (y == 0) begin
                    e.lo = '1;
                    e.hi = x;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one start pulse from an idle negedge; optionally push the
    // expected result. Returns the edge count at which the op was accepted.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input bit push,
                                 output int startEdge);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (push) begin
            sbQ.push_back(model(o, x, y));
        end
        @(negedge clk);
        start     = 1'b0;
        startEdge = cyc;
        checkOutput("busyAfterStart", 64'(busy), 64'd1);
    endtask

    // Wait (bounded) for done, then check latency, busy and the scoreboard.
    task automatic waitDone(input int startEdge, input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checkOutput({tag, "_doneTimeout"}, 64'(done), 64'd1);
        end else begin
            checkOutput({tag, "_latency"}, 64'(cyc - startEdge), 64'(LAT));
            checkOutput({tag, "_busyAtDone"}, 64'(busy), 64'd0);
            if (sbQ.size() == 0) begin
                checkOutput({tag, "_unexpectedDone"}, 64'(sbQ.size()), 64'd1);
            end else begin
                e = sbQ.pop_front();
                checkOutput({tag, "_hi"}, 64'(hi), 64'(e.hi));
                checkOutput({tag, "_lo"}, 64'(lo), 64'(e.lo));
                lastHi = e.hi;
                lastLo = e.lo;
            end
        end
    endtask

    // Count done pulses over n cycles (used where no result is allowed).
    task automatic countDone(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
            end
        end
    endtask

    initial begin
        int se;
        int dc;
        logic [1:0]   ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetDone", 64'(done), 64'd0);
        checkOutput("resetHi", 64'(hi), 64'd0);
        checkOutput("resetLo", 64'(lo), 64'd0);

        // Directed arithmetic, including the boundary cases.
        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, se);
        waitDone(se, "mult");
        @(negedge clk);
        checkOutput("donePulse", 64'(done), 64'd0);

        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, se);
        waitDone(se, "multu");
        // Back-to-back: next op launched in the done cycle.
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, se);
        waitDone(se, "divNeg");
        applyStimulus(2'b11, 32'd7, 32'd2, 1'b1, se);
        waitDone(se, "divu");
        applyStimulus(2'b10, 32'd5, 32'd0, 1'b1, se);
        waitDone(se, "divZero");
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1, se);
        waitDone(se, "divZeroNeg");
        applyStimulus(2'b11, 32'hDEAD_BEEF, 32'd0, 1'b1, se);
        waitDone(se, "divuZero");
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, se);
        waitDone(se, "divMinInt");
        applyStimulus(2'b00, 32'd0, 32'h8000_0000, 1'b1, se);
        waitDone(se, "multZero");
        applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, se);
        waitDone(se, "multMinMin");

        // Random ops; every third uses a small divisor/multiplier.
        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            @(negedge clk);
            applyStimulus(ro, rx, ry, 1'b1, se);
            waitDone(se, "rand");
        end

        // Cancel mid-ITER: no done, HI/LO keep prior values.
        @(negedge clk);
        applyStimulus(2'b00, 32'd1234567, 32'd89, 1'b0, se);
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checkOutput("cancelBusy", 64'(busy), 64'd0);
        checkOutput("cancelHi", 64'(hi), 64'(lastHi));
        checkOutput("cancelLo", 64'(lo), 64'(lastLo));
        countDone(40, dc);
        checkOutput("cancelNoDone", 64'(dc), 64'd0);

        // Start together with cancel in IDLE is dropped.
        op     = 2'b01;
        a      = 32'd3;
        b      = 32'd4;
        start  = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput("startCancelBusy", 64'(busy), 64'd0);

        // Start while busy is ignored: only the first op completes.
        applyStimulus(2'b01, 32'd5, 32'd6, 1'b1, se);
        repeat (3) @(negedge clk);
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(se, "startWhileBusy");
        countDone(40, dc);
        checkOutput("noQueuedOp", 64'(dc), 64'd0);

        // MTHI while busy is ignored; MTHI/MTLO when idle land.
        applyStimulus(2'b11, 32'd7, 32'd2, 1'b1, se);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        checkOutput("hiWeBusy", 64'(hi), 64'(lastHi));
        waitDone(se, "afterHiWe");
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        checkOutput("hiWeIdle", 64'(hi), 64'h1234);
        lo_we = 1'b1;
        wdata = 32'h0000_5678;
        @(negedge clk);
        lo_we = 1'b0;
        checkOutput("loWeIdle", 64'(lo), 64'h5678);

        // Write together with start lands, then the op overwrites it.
        hi_we = 1'b1;
        wdata = 32'h0000_AAAA;
        applyStimulus(2'b01, 32'd2, 32'd3, 1'b1, se);
        hi_we = 1'b0;
        checkOutput("hiWeWithStart", 64'(hi), 64'hAAAA);
        waitDone(se, "afterWeStart");

        // Reset mid-DIV clears everything immediately.
        @(negedge clk);
        applyStimulus(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0, se);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);
        checkOutput("rstHi", 64'(hi), 64'd0);
        checkOutput("rstLo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        countDone(40, dc);
        checkOutput("rstNoDone", 64'(dc), 64'd0);

        checkOutput("scoreboardEmpty", 64'(sbQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
